// File: rtl/lsnn_spike_logger.sv
// Spike event logger: ISI timestamping plus a valid/ready event FIFO.
// Define LSNN_RATE_EN to add the windowed spike-rate counter.
module lsnn_spike_logger #(
  parameter int FIFO_DEPTH    = 4,
  parameter int RATE_WIN_LOG2 = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          spike_in,
  input  logic [7:0]                    thresh_in,
  output logic [15:0]                   evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_count,
  output logic [7:0]                    rate_out,
  output logic                          rate_strobe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
  if (RATE_WIN_LOG2 < 1 || RATE_WIN_LOG2 > 24) begin : g_bad_win
    $error("RATE_WIN_LOG2 out of range");
  end

  logic [7:0]    isi_q, isi_d;
  logic [7:0]    isi_val;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [15:0]   mem_d [FIFO_DEPTH];
  logic          ovf_q, ovf_d;
  logic [7:0]    drop_q, drop_d;

  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic drop;

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = ~empty & evt_ready;
  assign push_ok = spike_in & (~full | pop);
  assign drop    = spike_in & full & ~pop;

  // ISI reported at a spike counts the spike edge itself
  always_comb begin
    isi_val = (isi_q == 8'hFF) ? 8'hFF : isi_q + 8'd1;
    isi_d   = isi_q;
    if (spike_in) begin
      isi_d = '0;
    end else if (isi_q != 8'hFF) begin
      isi_d = isi_q + 8'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = {isi_val, thresh_in};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      isi_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      isi_q    <= isi_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign evt_data   = mem_q[rd_ptr_q];
  assign evt_valid  = ~empty;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

`ifdef LSNN_RATE_EN
  logic [RATE_WIN_LOG2-1:0] win_q, win_d;
  logic [7:0]               spk_q, spk_d;
  logic [7:0]               rate_q, rate_d;
  logic                     strobe_q, strobe_d;
  logic [7:0]               spk_inc;

  // A spike on the window's last edge still belongs to that window
  always_comb begin
    spk_inc  = (spk_q == 8'hFF) ? spk_q : spk_q + 8'(spike_in);
    win_d    = win_q + RATE_WIN_LOG2'(1);
    spk_d    = spk_inc;
    rate_d   = rate_q;
    strobe_d = 1'b0;
    if (&win_q) begin
      rate_d   = spk_inc;
      strobe_d = 1'b1;
      spk_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win_q    <= '0;
      spk_q    <= '0;
      rate_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      win_q    <= win_d;
      spk_q    <= spk_d;
      rate_q   <= rate_d;
      strobe_q <= strobe_d;
    end
  end

  assign rate_out    = rate_q;
  assign rate_strobe = strobe_q;
`else
  assign rate_out    = '0;
  assign rate_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_lsnn_spike_logger.sv
// Bench for lsnn_spike_logger: directed steps plus random traffic
// checked against a queue-based event model.
module tb_lsnn_spike_logger;

  localparam int DEPTH = 4;
  localparam int WLOG  = 4;
  localparam int WIN   = 1 << WLOG;

  logic        clk;
  logic        rst_n;
  logic        spike_in;
  logic [7:0]  thresh_in;
  logic [15:0] evt_data;
  logic        evt_valid;
  logic        evt_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [7:0]  rate_out;
  logic        rate_strobe;

  lsnn_spike_logger #(
    .FIFO_DEPTH(DEPTH),
    .RATE_WIN_LOG2(WLOG)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spike_in(spike_in),
    .thresh_in(thresh_in),
    .evt_data(evt_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .drop_count(drop_count),
    .rate_out(rate_out),
    .rate_strobe(rate_strobe)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int compared;
  int mismatched;

  logic [15:0] mq[$];
  int          gap;
  int          m_drops;
  bit          m_ovf;
  int          edge_n;
  int          win_spk;
  int          m_rate;
  bit          m_strobe;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    gap      = 0;
    m_drops  = 0;
    m_ovf    = 0;
    edge_n   = 0;
    win_spk  = 0;
    m_rate   = 0;
    m_strobe = 0;
  endtask

  task automatic model_edge(input bit s, input logic [7:0] t, input bit r);
    int  sz;
    int  isi;
    bit  p;
    sz  = mq.size();
    p   = (sz > 0) && r;
    isi = (gap + 1 > 255) ? 255 : gap + 1;
    if (p) void'(mq.pop_front());
    if (s) begin
      if (sz < DEPTH || p) begin
        mq.push_back({8'(isi), t});
      end else begin
        m_ovf   = 1;
        m_drops = (m_drops < 255) ? m_drops + 1 : 255;
      end
      gap = 0;
    end else begin
      gap++;
    end
    edge_n++;
`ifdef LSNN_RATE_EN
    win_spk += int'(s);
    if (edge_n % WIN == 0) begin
      m_rate   = (win_spk > 255) ? 255 : win_spk;
      m_strobe = 1;
      win_spk  = 0;
    end else begin
      m_strobe = 0;
    end
`endif
  endtask

  task automatic check_all();
    chk("valid", 16'(evt_valid), 16'(mq.size() != 0));
    chk("count", 16'(fifo_count), 16'(mq.size()));
    if (mq.size() != 0) chk("head", evt_data, mq[0]);
    chk("overflow", 16'(overflow), 16'(m_ovf));
    chk("drops", 16'(drop_count), 16'(m_drops));
    chk("rate", 16'(rate_out), 16'(m_rate));
    chk("strobe", 16'(rate_strobe), 16'(m_strobe));
  endtask

  task automatic step(input bit s, input logic [7:0] t, input bit r);
    spike_in  = s;
    thresh_in = t;
    evt_ready = r;
    @(posedge clk);
    model_edge(s, t, r);
    #1;
    check_all();
  endtask

  // Called just after a sampling point; asserts reset between edges
  task automatic do_reset();
    #1;
    rst_n = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 16'(evt_valid), 16'd0);
    chk("rst_count", 16'(fifo_count), 16'd0);
    chk("rst_data", evt_data, 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_drops", 16'(drop_count), 16'd0);
    chk("rst_rate", 16'(rate_out), 16'd0);
    chk("rst_strobe", 16'(rate_strobe), 16'd0);
    spike_in  = 1'b0;
    evt_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b1;
    spike_in   = 1'b0;
    thresh_in  = 8'h00;
    evt_ready  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // first edge after reset
    step(1, 8'h10, 1);
    chk("first_evt", evt_data, 16'h0110);
    chk("first_valid", 16'(evt_valid), 16'd1);
    step(0, 8'h00, 1);

    // ISI values 1,1,5
    do_reset();
    step(1, 8'h21, 0);
    step(1, 8'h22, 0);
    for (int i = 3; i <= 6; i++) step(0, 8'h00, 0);
    step(1, 8'h27, 0);
    chk("isi_count", 16'(fifo_count), 16'd3);
    chk("isi_a", 16'(evt_data[15:8]), 16'd1);
    step(0, 8'h00, 1);
    chk("isi_b", 16'(evt_data[15:8]), 16'd1);
    step(0, 8'h00, 1);
    chk("isi_c", 16'(evt_data[15:8]), 16'd5);
    step(0, 8'h00, 1);

    // long gap saturates
    for (int i = 0; i < 300; i++) step(0, 8'h00, 0);
    step(1, 8'h33, 0);
    chk("isi_sat", evt_data, 16'hFF33);
    step(0, 8'h00, 1);

    // overflow: six spikes into depth four
    do_reset();
    for (int i = 1; i <= 6; i++) step(1, 8'(i), 0);
    chk("ovf_count", 16'(fifo_count), 16'd4);
    chk("ovf_flag", 16'(overflow), 16'd1);
    chk("ovf_drops", 16'(drop_count), 16'd2);
    chk("ovf_head", 16'(evt_data[7:0]), 16'd1);

    // full with simultaneous push and pop
    step(1, 8'hAA, 1);
    chk("pp_count", 16'(fifo_count), 16'd4);
    chk("pp_drops", 16'(drop_count), 16'd2);
    chk("pp_head", 16'(evt_data[7:0]), 16'd2);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    chk("pp_tail", 16'(evt_data[7:0]), 16'hAA);

    // reset mid-traffic with a loaded FIFO and sticky overflow
    step(1, 8'h5A, 0);
    do_reset();

    // ten spikes with random gaps and random ready
    for (int n = 0; n < 10; n++) begin
      int g;
      g = int'($urandom_range(0, 12));
      for (int k = 0; k < g; k++) step(0, 8'h00, 1'($urandom_range(0, 1)));
      step(1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 8; k++) step(0, 8'h00, 1);
    chk("drain_empty", 16'(evt_valid), 16'd0);

    // sustained random traffic across pointer wraps
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 3) != 0));
    end

    // rate window: spike every other cycle
    do_reset();
    for (int k = 1; k <= 4 * WIN; k++) begin
      step(1'(k % 2), 8'h44, 1);
`ifdef LSNN_RATE_EN
      if (k % WIN == 0) begin
        chk("rate_win", 16'(rate_out), 16'd8);
        chk("rate_pulse", 16'(rate_strobe), 16'd1);
      end
`else
      chk("rate_off", 16'(rate_out), 16'd0);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lsnn_spike_logger.md
# lsnn_spike_logger

Downstream consumer of the LSNN neuron's spike output. Timestamps each spike with its inter-spike interval (ISI), captures the neuron's current adaptive threshold at spike time, and queues `{isi, threshold}` events in a small FIFO with a valid/ready output port. Off-chip or downstream logic can then drain spike activity without sampling every cycle.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event queue depth; must be a power of two, 2..16.
- `RATE_WIN_LOG2`, 8: rate window length is 2^RATE_WIN_LOG2 cycles. Used only with `LSNN_RATE_EN`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-high, named as the codebase names it.
- `spike_in` input 1: neuron spike, sampled every rising edge; 1 = spike.
- `thresh_in` input 8: neuron threshold, sampled together with `spike_in`.
- `evt_data` output 16: FIFO head; [15:8] = ISI, [7:0] = captured threshold.
- `evt_valid` output 1: FIFO not empty.
- `evt_ready` input 1: consumer accepts the head when `evt_valid & evt_ready` at a rising edge.
- `fifo_count` output clog2(FIFO_DEPTH)+1: current occupancy.
- `overflow` output 1: sticky; set when an event is dropped.
- `drop_count` output 8: number of dropped events, saturating at 255.
- `rate_out` output 8: spikes counted in the last complete window.
- `rate_strobe` output 1: one-cycle pulse when `rate_out` updates.

## Operation
- **ISI counter (8 bit):**
  - Reset value is 0.
  - On an edge with `spike_in`=0: increments, saturating at 255.
  - On an edge with `spike_in`=1: reported ISI = min(counter+1, 255), and the counter loads 0.
  - Back-to-back spikes therefore report ISI=1. A spike at the first edge after reset reports ISI=1.
- **Push:** on every spike edge, attempt to push `{isi, thresh_in}`.
- **Pop:** at an edge where `evt_valid & evt_ready`, the head is removed.
- **Full FIFO:**
  - A push with no simultaneous pop is dropped: `overflow` is set and `drop_count` is incremented (saturating).
  - A push with a simultaneous pop is accepted, and the count is unchanged.
- **Empty FIFO with spike and `evt_ready`=1:** no pop occurs (the valid state is the registered one). The event is pushed and appears next cycle.
- **Ordering:** strict FIFO. Read and write pointers wrap modulo FIFO_DEPTH. Full/empty is decided by `fifo_count`.
- **`evt_data` stability:** stable while `evt_valid`=1 and no pop occurs. Don't-care (but driven from storage) when empty.
- **Clearing overflow:** `overflow` and `drop_count` clear only on reset.
- **Reset value of every output:**
  - `evt_valid`=0, `fifo_count`=0, `overflow`=0, `drop_count`=0, `rate_out`=0, `rate_strobe`=0.
  - `evt_data`=0 (storage cleared).
- **Reset mid-operation:** asynchronously flushes the FIFO, zeroes the ISI and window counters, and drops any in-flight push.

## Timing
- Spike-to-valid latency: 1 cycle. A spike sampled at edge N with an empty FIFO gives `evt_valid`=1 after edge N.
- Pop takes effect at the edge. The next head, or `evt_valid`=0, is visible after that edge.
- The consumer may hold `evt_ready`=1 permanently. Sustained throughput is 1 event per cycle.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.
- The rate window counter is free-running from reset. `rate_strobe` is asserted in the cycle after the window's final edge.

## Configuration
- `LSNN_RATE_EN` defined:
  - Adds the windowed spike-rate counter.
  - Counts spikes over each 2^RATE_WIN_LOG2-cycle window, saturating at 255.
  - At the window's last edge, latches the count into `rate_out` (including a spike on that edge), pulses `rate_strobe`, and restarts from 0.
- Not defined:
  - No rate logic is synthesized.
  - `rate_out` is tied to 0 and `rate_strobe` is tied to 0.
  - The FIFO and ISI behaviour are identical in both builds.

## Test plan
- **Reset mid-traffic:** reset, then a spike at edge 1 with `thresh_in`=0x10 → `evt_data`=0x0110 and `evt_valid`=1 after edge 1. Asserting `rst_n` mid-traffic → all outputs are 0 immediately, without waiting for an edge.
- **ISI values:** spikes at edges 1, 2 and 7 with `evt_ready`=0 → queued ISIs are 1, 1, 5 and `fifo_count`=3. A 300-cycle gap before the next spike → ISI 255.
- **Overflow:** 6 consecutive spikes with `evt_ready`=0 and depth 4 → `fifo_count`=4, `overflow`=1, `drop_count`=2. The entries retained are the first four.
- **Full with simultaneous push/pop:** FIFO full, `evt_ready`=1 and a spike on the same edge → `fifo_count` stays 4, no drop, and the new event appears at the tail.
- **Pointer wrap and ordering:** 10 spikes with random gaps and random `evt_ready` → the consumer receives events in order with correct ISIs, and no loss while `fifo_count` < 4.
- **Rate counter:** `LSNN_RATE_EN` with `RATE_WIN_LOG2`=4 and a spike every other cycle → `rate_strobe` pulses every 16 cycles with `rate_out`=8. Without the macro, `rate_out`=0 throughout.
